wash_cycle_ctrl: RTL and testbench

Top-level cycle sequencer for the washing-machine controller. After a coin is accepted it steps the machine through fill, wash, rinse and spin, with an optional second wash/rinse pass, and drives the valve, motor and drain outputs. Each phase lasts a programmed number of clock ticks, counted by an internal phase timer that the controller clears and enables. A pause input freezes the running phase without losing progress.

---
 rtl/wash_pkg.sv | 40 ++++
 rtl/wash_cycle_ctrl_phase_timer.sv | 29 ++
 rtl/wash_cycle_ctrl.sv | 127 ++++++++++++
 tb/tb_wash_cycle_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine cycle controller.
package wash_pkg;

  // Width of phase durations and of the phase counter.
  localparam int DUR_W = 8;

  // Default timing: clock ticks per time unit and per-phase time units.
  localparam int unsigned DEF_CLK_FREQ     = 4;
  localparam int unsigned DEF_FILL_PERIOD  = 2;
  localparam int unsigned DEF_WASH_PERIOD  = 5;
  localparam int unsigned DEF_RINSE_PERIOD = 2;
  localparam int unsigned DEF_SPIN_PERIOD  = 1;

  typedef logic [DUR_W-1:0] dur_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4
  } state_t;

  // Registered machine outputs other than the state code.
  typedef struct packed {
    logic water_valve;
    logic motor_on;
    logic drain;
    logic busy;
    logic wash_done;
  } outs_t;

  // Phase length in clock ticks, kept as an 8-bit unsigned product.
  function automatic dur_t phase_len(input int unsigned freq, input int unsigned period);
    int unsigned prod;
    prod = freq * period;
    return dur_t'(prod);
  endfunction

endpackage

// File: rtl/wash_cycle_ctrl_phase_timer.sv
// Phase timer: counts enabled ticks and flags the last tick of a phase.
module phase_timer
  import wash_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  dur_t limit,
  output logic terminal
);

  dur_t count;

  assign terminal = en && (count == (limit - dur_t'(1)));

  // Count enabled ticks; a clear wins over the enable so the phase change edge restarts at 0.
  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + dur_t'(1);
    end
  end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Wash cycle sequencer: IDLE -> FILL -> WASH -> RINSE (-> WASH -> RINSE) -> SPIN -> IDLE.
module wash_cycle_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
  parameter int unsigned FILL_PERIOD  = DEF_FILL_PERIOD,
  parameter int unsigned WASH_PERIOD  = DEF_WASH_PERIOD,
  parameter int unsigned RINSE_PERIOD = DEF_RINSE_PERIOD,
  parameter int unsigned SPIN_PERIOD  = DEF_SPIN_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  output logic [2:0] state,
  output logic       water_valve,
  output logic       motor_on,
  output logic       drain,
  output logic       busy,
  output logic       wash_done
);

  localparam dur_t N_FILL  = phase_len(CLK_FREQ, FILL_PERIOD);
  localparam dur_t N_WASH  = phase_len(CLK_FREQ, WASH_PERIOD);
  localparam dur_t N_RINSE = phase_len(CLK_FREQ, RINSE_PERIOD);
  localparam dur_t N_SPIN  = phase_len(CLK_FREQ, SPIN_PERIOD);

  state_t cur_state;
  state_t nxt_state;
  outs_t  outs_nxt;
  dur_t   limit;
  logic   dw_flag;
  logic   second_pass;
  logic   tmr_en;
  logic   tmr_clr;
  logic   terminal;

  // The timer runs in any active phase unless paused, and restarts on every state entry.
  assign tmr_en  = (cur_state != ST_IDLE) && !timer_pause;
  assign tmr_clr = (nxt_state != cur_state) || (cur_state == ST_IDLE);

  // Select the duration of the phase currently running.
  always_comb begin
    limit = N_FILL;
    case (cur_state)
      ST_WASH:  limit = N_WASH;
      ST_RINSE: limit = N_RINSE;
      ST_SPIN:  limit = N_SPIN;
      default:  limit = N_FILL;
    endcase
  end

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .limit    (limit),
    .terminal (terminal)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; terminal already folds in the pause, so a paused phase holds.
  // NOTE: a default assignment first keeps every path assigned and avoids an inferred latch.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE:  if (coin_in)  nxt_state = ST_FILL;
      ST_FILL:  if (terminal) nxt_state = ST_WASH;
      ST_WASH:  if (terminal) nxt_state = ST_RINSE;
      ST_RINSE: if (terminal) nxt_state = (dw_flag && !second_pass) ? ST_WASH : ST_SPIN;
      ST_SPIN:  if (terminal) nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state so outputs change on the same edge as state.
  always_comb begin
    outs_nxt = '0;
    case (nxt_state)
      ST_FILL:  begin outs_nxt.water_valve = 1'b1; outs_nxt.busy = 1'b1; end
      ST_WASH:  begin outs_nxt.motor_on = 1'b1; outs_nxt.busy = 1'b1; end
      ST_RINSE,
      ST_SPIN:  begin
        outs_nxt.motor_on = 1'b1;
        outs_nxt.drain    = 1'b1;
        outs_nxt.busy     = 1'b1;
      end
      default:  outs_nxt = '0;
    endcase
    outs_nxt.wash_done = (cur_state == ST_SPIN) && (nxt_state == ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {water_valve, motor_on, drain, busy, wash_done} <= '0;
    end else begin
      {water_valve, motor_on, drain, busy, wash_done} <= outs_nxt;
    end
  end

  // Double-wash request is captured with the coin; the second pass is marked on RINSE->WASH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dw_flag     <= 1'b0;
      second_pass <= 1'b0;
    end else if ((cur_state == ST_IDLE) && coin_in) begin
      dw_flag     <= double_wash;
      second_pass <= 1'b0;
    end else if ((cur_state == ST_RINSE) && (nxt_state == ST_WASH)) begin
      second_pass <= 1'b1;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl: vector table plus multi-cycle sequences.
module tb_wash_cycle_ctrl;
  import wash_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin;
  logic       double_wash;
  logic       timer_pause;
  logic [1:0] sel;
  logic [2:0] coin_v;
  logic [7:0] ob [3];   // {state, valve, motor, drain, busy, done} per instance
  logic [7:0] mon;
  logic [2:0] m_st;
  logic [4:0] m_o;      // {valve, motor, drain, busy, done}

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign coin_v = {coin && (sel == 2'd2), coin && (sel == 2'd1), coin && (sel == 2'd0)};

  always_comb begin
    mon = ob[0];
    if (sel == 2'd1) mon = ob[1];
    if (sel == 2'd2) mon = ob[2];
  end
  assign m_st = mon[7:5];
  assign m_o  = mon[4:0];

  // Test-plan timing: N = 4/10/4/2.
  wash_cycle_ctrl #(.CLK_FREQ(2), .FILL_PERIOD(2), .WASH_PERIOD(5), .RINSE_PERIOD(2), .SPIN_PERIOD(1)) dut (
    .clk(clk), .reset(reset), .coin_in(coin_v[0]), .double_wash(double_wash), .timer_pause(timer_pause),
    .state(ob[0][7:5]), .water_valve(ob[0][4]), .motor_on(ob[0][3]), .drain(ob[0][2]),
    .busy(ob[0][1]), .wash_done(ob[0][0]));

  // Largest phase: N = 15/225/15/15.
  wash_cycle_ctrl #(.CLK_FREQ(15), .FILL_PERIOD(1), .WASH_PERIOD(15), .RINSE_PERIOD(1), .SPIN_PERIOD(1)) dut_big (
    .clk(clk), .reset(reset), .coin_in(coin_v[1]), .double_wash(double_wash), .timer_pause(timer_pause),
    .state(ob[1][7:5]), .water_valve(ob[1][4]), .motor_on(ob[1][3]), .drain(ob[1][2]),
    .busy(ob[1][1]), .wash_done(ob[1][0]));

  // Smallest phase: N = 1 everywhere.
  wash_cycle_ctrl #(.CLK_FREQ(1), .FILL_PERIOD(1), .WASH_PERIOD(1), .RINSE_PERIOD(1), .SPIN_PERIOD(1)) dut_min (
    .clk(clk), .reset(reset), .coin_in(coin_v[2]), .double_wash(double_wash), .timer_pause(timer_pause),
    .state(ob[2][7:5]), .water_valve(ob[2][4]), .motor_on(ob[2][3]), .drain(ob[2][2]),
    .busy(ob[2][1]), .wash_done(ob[2][0]));

  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_FILL = 5'b10010;
  localparam logic [4:0] O_WASH = 5'b01010;
  localparam logic [4:0] O_RS   = 5'b01110;
  localparam logic [4:0] O_DONE = 5'b00001;

  typedef struct {
    logic       coin;
    logic       dw;
    logic       pause;
    int         n;      // edges to apply before checking
    logic [2:0] st;
    logic [4:0] o;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic d, input logic p, input int n,
                              input logic [2:0] s, input logic [4:0] o);
    vec_t v;
    v.coin = c; v.dw = d; v.pause = p; v.n = n; v.st = s; v.o = o;
    return v;
  endfunction

  // Reference decode of {valve, motor, drain, busy} from a state code.
  function automatic logic [3:0] exp_outs(input logic [2:0] s);
    case (s)
      3'd1:      return 4'b1001;
      3'd2:      return 4'b0101;
      3'd3, 3'd4: return 4'b0111;
      default:   return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Start a cycle on the selected instance and follow it until busy drops, then one more edge.
  task automatic run_cycle(input logic dw, input logic toggle, input int pause_at, input logic hold_coin,
                           input logic [2:0] track, output int busy_len, output int track_len,
                           output int dones, output logic [23:0] seq, output int bad);
    logic [2:0] prev;
    coin = 1'b1;
    double_wash = dw;
    timer_pause = 1'b0;
    step();
    if (!hold_coin) coin = 1'b0;
    busy_len = 0; track_len = 0; dones = 0; seq = '0; bad = 0; prev = 3'd0;
    for (int k = 0; k < 600; k++) begin
      if (m_o[0]) dones++;
      if (!m_o[1]) break;
      busy_len++;
      if (m_st == track) track_len++;
      if (m_st != prev) seq = {seq[20:0], m_st};
      prev = m_st;
      if (m_o[4:1] != exp_outs(m_st)) bad++;
      if (toggle) double_wash = ~double_wash;
      if (busy_len == pause_at) timer_pause = 1'b1;
      if (busy_len == pause_at + 3) timer_pause = 1'b0;
      step();
    end
    step();
    if (m_o[0]) dones++;
  endtask

  int         bl, tl, dn, bad, cnt;
  logic [23:0] sq;

  initial begin
    reset = 1'b1; coin = 1'b0; double_wash = 1'b0; timer_pause = 1'b0; sel = 2'd0;
    #3;
    check("reset state", m_st, 0);
    check("reset outputs", m_o, O_IDLE);
    step();
    step();
    reset = 1'b0;

    // Single cycle with coin/double_wash pressed in RINSE (ignored).
    vecs.push_back(mk(1, 0, 0, 1, ST_FILL,  O_FILL));
    vecs.push_back(mk(0, 0, 0, 3, ST_FILL,  O_FILL));
    vecs.push_back(mk(0, 0, 0, 1, ST_WASH,  O_WASH));
    vecs.push_back(mk(0, 0, 0, 9, ST_WASH,  O_WASH));
    vecs.push_back(mk(0, 0, 0, 1, ST_RINSE, O_RS));
    vecs.push_back(mk(1, 1, 0, 3, ST_RINSE, O_RS));
    vecs.push_back(mk(0, 0, 0, 1, ST_SPIN,  O_RS));
    vecs.push_back(mk(0, 0, 0, 1, ST_SPIN,  O_RS));
    vecs.push_back(mk(0, 0, 0, 1, ST_IDLE,  O_DONE));
    vecs.push_back(mk(0, 0, 0, 1, ST_IDLE,  O_IDLE));
    // Pause 3 cycles at WASH count 5, then pause on SPIN terminal count.
    vecs.push_back(mk(1, 0, 0, 1, ST_FILL,  O_FILL));
    vecs.push_back(mk(0, 0, 0, 4, ST_WASH,  O_WASH));
    vecs.push_back(mk(0, 0, 0, 5, ST_WASH,  O_WASH));
    vecs.push_back(mk(0, 0, 1, 3, ST_WASH,  O_WASH));
    vecs.push_back(mk(0, 0, 0, 4, ST_WASH,  O_WASH));
    vecs.push_back(mk(0, 0, 0, 1, ST_RINSE, O_RS));
    vecs.push_back(mk(0, 0, 0, 4, ST_SPIN,  O_RS));
    vecs.push_back(mk(0, 0, 0, 1, ST_SPIN,  O_RS));
    vecs.push_back(mk(0, 0, 1, 2, ST_SPIN,  O_RS));
    vecs.push_back(mk(0, 0, 0, 1, ST_IDLE,  O_DONE));
    // Coin accepted while pause is high; pause then holds FILL.
    vecs.push_back(mk(1, 0, 1, 1, ST_FILL,  O_FILL));
    vecs.push_back(mk(0, 0, 1, 5, ST_FILL,  O_FILL));
    vecs.push_back(mk(0, 0, 0, 4, ST_WASH,  O_WASH));

    foreach (vecs[i]) begin
      coin = vecs[i].coin;
      double_wash = vecs[i].dw;
      timer_pause = vecs[i].pause;
      repeat (vecs[i].n) step();
      check($sformatf("vec%0d state", i), m_st, vecs[i].st);
      check($sformatf("vec%0d outputs", i), m_o, vecs[i].o);
    end
    coin = 1'b0; timer_pause = 1'b0;
    do_reset();

    // Single cycle; double_wash toggling after acceptance has no effect.
    run_cycle(1'b0, 1'b1, -100, 1'b0, ST_WASH, bl, tl, dn, sq, bad);
    check("single busy", bl, 20);
    check("single wash len", tl, 10);
    check("single done pulses", dn, 1);
    check("single sequence", int'(sq), int'(24'o1234));
    check("single output decode", bad, 0);

    // Double wash with double_wash toggling mid-cycle.
    run_cycle(1'b1, 1'b1, -100, 1'b0, ST_WASH, bl, tl, dn, sq, bad);
    check("double busy", bl, 34);
    check("double wash len", tl, 20);
    check("double done pulses", dn, 1);
    check("double sequence", int'(sq), int'(24'o123234));
    check("double output decode", bad, 0);

    // Pause for 3 cycles at WASH count 5.
    run_cycle(1'b0, 1'b0, 10, 1'b0, ST_WASH, bl, tl, dn, sq, bad);
    check("pause busy", bl, 23);
    check("pause wash len", tl, 13);
    check("pause done pulses", dn, 1);
    check("pause output decode", bad, 0);

    // Reset asserted mid-RINSE.
    coin = 1'b1;
    step();
    coin = 1'b0;
    repeat (15) step();
    check("pre-reset state", m_st, ST_RINSE);
    #2 reset = 1'b1;
    #1;
    check("async reset state", m_st, 0);
    check("async reset outputs", m_o, O_IDLE);
    step();
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (m_o[0] || m_st != 3'd0) cnt++;
      step();
    end
    check("post-reset quiet", cnt, 0);
    run_cycle(1'b0, 1'b0, -100, 1'b0, ST_FILL, bl, tl, dn, sq, bad);
    check("post-reset fill len", tl, 4);
    check("post-reset busy", bl, 20);

    // Coin held high through the whole cycle and across SPIN->IDLE.
    run_cycle(1'b0, 1'b0, -100, 1'b1, ST_WASH, bl, tl, dn, sq, bad);
    check("held coin busy", bl, 20);
    check("held coin done pulses", dn, 1);
    check("held coin restart state", m_st, ST_FILL);
    coin = 1'b0;
    do_reset();

    // Largest duration: WASH lasts 225 cycles.
    sel = 2'd1;
    run_cycle(1'b0, 1'b0, -100, 1'b0, ST_WASH, bl, tl, dn, sq, bad);
    check("big wash len", tl, 225);
    check("big busy", bl, 270);
    check("big done pulses", dn, 1);

    // Smallest duration: one cycle per state.
    sel = 2'd2;
    run_cycle(1'b0, 1'b0, -100, 1'b0, ST_SPIN, bl, tl, dn, sq, bad);
    check("min busy", bl, 4);
    check("min spin len", tl, 1);
    check("min sequence", int'(sq), int'(24'o1234));
    check("min done pulses", dn, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
